// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//
// Shared definitions for the bit-serial adder controller:
//   state_t    - FSM state encoding (IDLE / SHIFT / DONE)
//   cnt_width  - width of the bit counter for a given operand width,
//                i.e. $clog2(width), never less than one bit
// ---------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage : serial_add_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//
// One-bit full-adder cell.
//   A, B  - addend bits
//   Cin   - carry in
//   Y     - sum bit
//   Cout  - carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Cout
);

    assign Y    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder: computes (a + b + cin) mod 2^WIDTH one bit per clock,
// LSB first, through a single full_adder cell and a registered carry.
// A run takes WIDTH cycles in SHIFT followed by one DONE cycle; start is
// accepted in IDLE or DONE (back-to-back operation without an idle gap).
//
// Parameters
//   WIDTH  - operand / result width, 2..32
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new addition
//   a, b   in   operands, captured on an accepted start
//   cin    in   carry in, captured on an accepted start
//   busy   out  high while bits are being processed (SHIFT)
//   done   out  one-cycle pulse: sum/cout/ovf are valid
//   sum    out  result, held from DONE until the next accepted start
//   cout   out  carry out of bit WIDTH-1
//   ovf    out  signed overflow flag
//
// Build option
//   SERIAL_ADD_OVF_EN  - when defined, ovf reports two's-complement
//                        overflow; otherwise ovf is tied to 0.
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sum_r;
    logic               carry;
    logic               fa_y;
    logic               fa_cout;
    logic               accept;
    logic               last;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == LAST);

    // -----------------------------------------------------------------------
    // Per-bit datapath: LSBs of the operand shift registers plus the carry.
    // -----------------------------------------------------------------------
    full_adder u_fa (
        .A    (op_a[0]),
        .B    (op_b[0]),
        .Cin  (carry),
        .Y    (fa_y),
        .Cout (fa_cout)
    );

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and status outputs
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // start is deliberately not looked at here
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? SHIFT : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bit counter, carry and result shift register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            sum_r <= '0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= cin;
        end else if (state == SHIFT) begin
            cnt   <= last ? '0 : cnt + 1'b1;
            carry <= fa_cout;
            // Result enters at the MSB; after WIDTH shifts bit 0 lands at [0].
            sum_r <= {fa_y, sum_r[WIDTH-1:1]};
        end
    end

    // Operand shift registers carry no reset: they are only consumed in
    // SHIFT, which is always preceded by a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= a;
            op_b <= b;
        end else if (state == SHIFT) begin
            op_a <= {1'b0, op_a[WIDTH-1:1]};
            op_b <= {1'b0, op_b[WIDTH-1:1]};
        end
    end

    assign sum  = sum_r;
    // The carry register only moves in SHIFT or on a new start, so after
    // the last bit it already holds the final carry out.
    assign cout = carry;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;

    // On the MSB cycle, carry is the carry into the MSB and fa_cout the
    // carry out of it; they differ exactly on signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if ((state == SHIFT) && last) begin
            ovf_r <= carry ^ fa_cout;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl at WIDTH=8. Expected values are
// hand-computed constants; ovf expectations follow SERIAL_ADD_OVF_EN.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

`ifdef SERIAL_ADD_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one addition starting at the current (negedge) time.
    //   chain   : leave start asserted at DONE (caller issues the next op)
    //   glitch  : SHIFT cycle index at which to pulse start with junk operands
    //   rst_at  : SHIFT cycle index at which to assert reset and abandon
    task automatic run_op(input string tag,
                          input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit chain, input int glitch, input int rst_at);
        logic eo_eff;
        eo_eff = OVF_ON ? eo : 1'b0;
        start = 1'b1;
        a     = ta;
        b     = tb;
        cin   = tcin;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h5A;
        b     = 8'hC3;
        cin   = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
                chk({tag, "_rst_done"}, 32'(done), 32'd0);
                chk({tag, "_rst_sum"},  32'(sum),  32'd0);
                chk({tag, "_rst_cout"}, 32'(cout), 32'd0);
                chk({tag, "_rst_ovf"},  32'(ovf),  32'd0);
                // start while in reset must not be taken
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h01;
                repeat (2) @(posedge clk);
                #1;
                chk({tag, "_rst_hold_busy"}, 32'(busy), 32'd0);
                chk({tag, "_rst_hold_done"}, 32'(done), 32'd0);
                @(negedge clk);
                start = 1'b0;
                rst_n = 1'b1;
                return;
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            if (glitch >= 0 && i == glitch) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h01;
                cin   = 1'b0;
            end else if (glitch >= 0 && i == glitch + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sum"},  32'(sum),  32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"},  32'(ovf),  32'(eo_eff));
        if (!chain) begin
            @(negedge clk);
            chk({tag, "_idle_done"}, 32'(done), 32'd0);
            chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
            chk({tag, "_hold_sum"},  32'(sum),  32'(es));
            chk({tag, "_hold_cout"}, 32'(cout), 32'(ec));
            chk({tag, "_hold_ovf"},  32'(ovf),  32'(eo_eff));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;

        // start on the very first edge after reset release
        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, -1, -1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, -1, -1);
        run_op("add_7f_00c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, -1, -1);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, -1, -1);

        // start pulse in the middle of SHIFT is ignored
        run_op("ignore", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 3, -1);

        // reset on SHIFT cycle 4, then a clean op right after release
        run_op("abort", 8'h55, 8'h0A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, 3);
        run_op("after_rst", 8'h55, 8'h0A, 1'b0, 8'h5F, 1'b0, 1'b0, 1'b0, -1, -1);

        // back-to-back: start held through DONE
        run_op("b2b_1", 8'h05, 8'h06, 1'b0, 8'h0B, 1'b0, 1'b0, 1'b1, -1, -1);
        run_op("b2b_2", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_add_ctrl
